ws281x_recv: RTL and testbench



---
 rtl/ws281x_recv.sv | 158 +++++++++++++++
 tb/tb_ws281x_recv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_recv.sv
// WS281x line decoder: classifies pulses into bits and writes MSB-first bytes to a 64x4 byte-lane RAM.
// Optional macro WS281X_RECV_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module ws281x_recv (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        ws281x_data_in,
   input  logic [7:0]  bit_thr_cnt_in,
   input  logic [15:0] rst_cnt_in,
   output logic        wr_en_out,
   output logic [5:0]  wr_addr_out,
   output logic [7:0]  wr_data_out,
   output logic [3:0]  wr_byte_en_out,
   output logic        wr_done_out,
   output logic        err_out
);

   typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

   state_t      state;
   logic        sync_q1;
   logic        sync_q2;
   logic        line;
   logic        line_q;
   logic        rise;
   logic        fall;
   logic        pend_rise;
   logic [7:0]  high_cnt;
   logic [15:0] low_cnt;
   logic [15:0] rst_eff;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic [8:0]  byte_cnt;
   logic        new_bit;
   logic [7:0]  byte_nx;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= ws281x_data_in;
         sync_q2 <= sync_q1;
      end
   end

`ifdef WS281X_RECV_GLITCH_FILTER_EN
   logic tap1;
   logic tap2;
   logic filt_q;

   // Registered majority of three samples: single-cycle pulses never win.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tap1   <= 1'b0;
         tap2   <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         tap1   <= sync_q2;
         tap2   <= tap1;
         filt_q <= (sync_q2 & tap1) | (sync_q2 & tap2) | (tap1 & tap2);
      end
   end

   assign line = filt_q;
`else
   assign line = sync_q2;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) line_q <= 1'b0;
      else        line_q <= line;
   end

   assign rise    = line & ~line_q;
   assign fall    = ~line & line_q;
   assign rst_eff = (rst_cnt_in == 16'd0) ? 16'd1 : rst_cnt_in;
   assign new_bit = high_cnt > bit_thr_cnt_in;
   assign byte_nx = {shreg[6:0], new_bit};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= SYNC;
         pend_rise      <= 1'b0;
         high_cnt       <= 8'd0;
         low_cnt        <= 16'd0;
         shreg          <= 8'd0;
         bit_cnt        <= 3'd0;
         byte_cnt       <= 9'd0;
         wr_en_out      <= 1'b0;
         wr_addr_out    <= 6'd0;
         wr_data_out    <= 8'd0;
         wr_byte_en_out <= 4'd0;
         wr_done_out    <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         wr_en_out   <= 1'b0;
         wr_done_out <= 1'b0;
         err_out     <= 1'b0;
         unique case (state)
            SYNC: begin
               pend_rise <= 1'b0;
               if (line)                   low_cnt <= 16'd0;
               else if (low_cnt >= rst_eff) state  <= IDLE;
               else                        low_cnt <= low_cnt + 16'd1;
            end
            IDLE: begin
               if (rise || pend_rise) begin
                  state     <= HIGH;
                  high_cnt  <= 8'd1;
                  pend_rise <= 1'b0;
               end
            end
            HIGH: begin
               if (fall) begin
                  state   <= LOW;
                  low_cnt <= 16'd1;
                  shreg   <= byte_nx;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= 3'd0;
                     // Capacity is full once byte_cnt hits 256: drop and flag.
                     if (byte_cnt[8]) begin
                        err_out <= 1'b1;
                     end else begin
                        wr_en_out      <= 1'b1;
                        wr_addr_out    <= byte_cnt[7:2];
                        wr_data_out    <= byte_nx;
                        wr_byte_en_out <= 4'b0001 << byte_cnt[1:0];
                        byte_cnt       <= byte_cnt + 9'd1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else if (high_cnt != 8'hFF) begin
                  high_cnt <= high_cnt + 8'd1;
               end
            end
            LOW: begin
               // Frame end wins over a coincident rise; the rise is latched for IDLE.
               if (low_cnt >= rst_eff) begin
                  state       <= IDLE;
                  pend_rise   <= rise;
                  wr_done_out <= byte_cnt != 9'd0;
                  err_out     <= bit_cnt != 3'd0;
                  byte_cnt    <= 9'd0;
                  bit_cnt     <= 3'd0;
               end else if (rise) begin
                  state    <= HIGH;
                  high_cnt <= 8'd1;
               end else if (low_cnt != 16'hFFFF) begin
                  low_cnt <= low_cnt + 16'd1;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_ws281x_recv.sv
// Directed bench for ws281x_recv: table of single-byte frames plus multi-frame corner sequences.
module tb_ws281x_recv;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        ws281x_data_in;
   logic [7:0]  bit_thr_cnt_in;
   logic [15:0] rst_cnt_in;
   logic        wr_en_out;
   logic [5:0]  wr_addr_out;
   logic [7:0]  wr_data_out;
   logic [3:0]  wr_byte_en_out;
   logic        wr_done_out;
   logic        err_out;

`ifdef WS281X_RECV_GLITCH_FILTER_EN
   localparam int LAT       = 2;
   localparam int SPIKE_ERR = 0;
`else
   localparam int LAT       = 0;
   localparam int SPIKE_ERR = 1;
`endif

   ws281x_recv dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .ws281x_data_in (ws281x_data_in),
      .bit_thr_cnt_in (bit_thr_cnt_in),
      .rst_cnt_in     (rst_cnt_in),
      .wr_en_out      (wr_en_out),
      .wr_addr_out    (wr_addr_out),
      .wr_data_out    (wr_data_out),
      .wr_byte_en_out (wr_byte_en_out),
      .wr_done_out    (wr_done_out),
      .err_out        (err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [5:0] a;
      logic [7:0] d;
      logic [3:0] be;
   } wr_t;

   typedef struct {
      int         thr;
      int         h1;
      int         h0;
      int         per;
      logic [7:0] din;
      logic [7:0] dexp;
   } vec_t;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   wr_cyc = 0;
   int   done_cyc = 0;
   int   last_fall = 0;
   int   hi1 = 70;
   int   hi0 = 35;
   int   per = 125;
   wr_t  wq[$];
   vec_t vt[6];

   always @(posedge clk_in) cyc++;

   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (wr_en_out) begin
            wq.push_back({wr_addr_out, wr_data_out, wr_byte_en_out});
            wr_cyc = cyc;
         end
         if (wr_done_out) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err_out) err_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic clr();
      wq.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic timing(input int thr, input int h1, input int h0, input int p);
      bit_thr_cnt_in = thr[7:0];
      hi1 = h1;
      hi0 = h0;
      per = p;
   endtask

   task automatic send_bit(input logic b);
      int h;
      h = b ? hi1 : hi0;
      ws281x_data_in = 1'b1;
      tick(h);
      ws281x_data_in = 1'b0;
      last_fall = cyc;
      tick(per - h);
   endtask

   task automatic send_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic gap();
      ws281x_data_in = 1'b0;
      tick(int'(rst_cnt_in) + 20);
   endtask

   task automatic chk_single(input string nm, input logic [5:0] a,
                             input logic [7:0] d, input int errs);
      wr_t w;
      w = (wq.size() > 0) ? wq[wq.size() - 1] : '0;
      chk({nm, " writes"}, wq.size(), 1);
      chk({nm, " addr"}, int'(w.a), int'(a));
      chk({nm, " data"}, int'(w.d), int'(d));
      chk({nm, " byte_en"}, int'(w.be), 1);
      chk({nm, " done"}, done_cnt, 1);
      chk({nm, " err"}, err_cnt, errs);
   endtask

   initial begin
      vt[0] = '{60, 70, 35, 125, 8'h3C, 8'h3C};
      vt[1] = '{20, 30, 10, 50, 8'hFF, 8'hFF};
      vt[2] = '{20, 21, 20, 50, 8'h96, 8'h96};
      vt[3] = '{20, 20, 20, 50, 8'hFF, 8'h00};
      vt[4] = '{0, 2, 2, 10, 8'h55, 8'hFF};
      vt[5] = '{255, 300, 10, 320, 8'hFF, 8'h00};

      rst_in         = 1'b1;
      ws281x_data_in = 1'b0;
      bit_thr_cnt_in = 8'd60;
      rst_cnt_in     = 16'd4000;
      tick(3);
      chk("rst wr_en", int'(wr_en_out), 0);
      chk("rst addr", int'(wr_addr_out), 0);
      chk("rst data", int'(wr_data_out), 0);
      chk("rst byte_en", int'(wr_byte_en_out), 0);
      chk("rst done", int'(wr_done_out), 0);
      chk("rst err", int'(err_out), 0);
      rst_in = 1'b0;

      // Basic A5 frame with exact latencies.
      timing(60, 70, 35, 125);
      tick(4010);
      clr();
      send_byte(8'hA5);
      chk("a5 wr latency", wr_cyc - last_fall, 3 + LAT);
      gap();
      chk_single("a5", 6'd0, 8'hA5, 0);
      chk("a5 done latency", done_cyc - last_fall, 4000 + 3 + LAT);

      rst_cnt_in = 16'd200;
      for (int v = 0; v < 6; v++) begin
         timing(vt[v].thr, vt[v].h1, vt[v].h0, vt[v].per);
         clr();
         send_byte(vt[v].din);
         gap();
         chk_single($sformatf("vec%0d", v), 6'd0, vt[v].dexp, 0);
      end

      // Twelve bytes: addresses and lanes advance per byte.
      timing(6, 8, 3, 12);
      clr();
      for (int i = 0; i < 12; i++) send_byte(8'(i));
      gap();
      chk("x12 writes", wq.size(), 12);
      for (int i = 0; i < 12 && i < wq.size(); i++) begin
         chk($sformatf("x12 addr%0d", i), int'(wq[i].a), i / 4);
         chk($sformatf("x12 be%0d", i), int'(wq[i].be), 1 << (i % 4));
         chk($sformatf("x12 data%0d", i), int'(wq[i].d), i);
      end
      chk("x12 done", done_cnt, 1);
      chk("x12 err", err_cnt, 0);

      // Overflow: byte 257 is dropped with one error.
      clr();
      for (int i = 0; i < 257; i++) send_byte(8'(i));
      gap();
      chk("ovf writes", wq.size(), 256);
      if (wq.size() > 0) begin
         chk("ovf last addr", int'(wq[wq.size() - 1].a), 63);
         chk("ovf last be", int'(wq[wq.size() - 1].be), 8);
         chk("ovf last data", int'(wq[wq.size() - 1].d), 255);
      end
      chk("ovf err", err_cnt, 1);
      chk("ovf done", done_cnt, 1);

      // Eleven bits: partial byte flagged at frame end, next frame restarts at 0.
      clr();
      send_byte(8'hC3);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      gap();
      chk_single("part", 6'd0, 8'hC3, 1);
      clr();
      send_byte(8'h5A);
      gap();
      chk_single("part next", 6'd0, 8'h5A, 0);

      // Reset mid-frame, then bits before the first gap are ignored.
      clr();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst_in = 1'b1;
      ws281x_data_in = 1'b0;
      tick(2);
      rst_in = 1'b0;
      send_byte(8'hFF);
      gap();
      chk("presync writes", wq.size(), 0);
      chk("presync done", done_cnt, 0);
      chk("presync err", err_cnt, 0);
      clr();
      send_byte(8'h81);
      gap();
      chk_single("postsync", 6'd0, 8'h81, 0);

      // Single-cycle spike in the trailing low time.
      timing(60, 70, 35, 125);
      clr();
      send_byte(8'hA5);
      tick(20);
      ws281x_data_in = 1'b1;
      tick(1);
      ws281x_data_in = 1'b0;
      gap();
      chk_single("spike", 6'd0, 8'hA5, SPIKE_ERR);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
